// File: rtl/axi4_burst_master.sv
// axi4_burst_master: splits word-granular read/write commands into AXI4 INCR bursts that never cross 4 KB
// Ports: clk_i/rst_i clock and asynchronous active-high reset; cmd_* command handshake (write flag,
//   byte address, word count); wr_* write-data stream in; rd_* read-data stream out; busy_o/done_o/err_o
//   status; axi_aw*/axi_w*/axi_b*/axi_ar*/axi_r* AXI4 initiator channels (one burst outstanding).
module axi4_burst_master #(
    parameter int         MAX_BURST = 16,
    parameter logic [4:0] AXI_ID    = 5'd0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [15:0] cmd_words_i,
    input  logic        wr_valid_i,
    output logic        wr_ready_o,
    input  logic [31:0] wr_data_i,
    input  logic [3:0]  wr_strb_i,
    output logic        rd_valid_o,
    input  logic        rd_ready_i,
    output logic [31:0] rd_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        axi_awvalid_o,
    input  logic        axi_awready_i,
    output logic [31:0] axi_awaddr_o,
    output logic [4:0]  axi_awid_o,
    output logic [7:0]  axi_awlen_o,
    output logic [1:0]  axi_awburst_o,
    output logic        axi_wvalid_o,
    input  logic        axi_wready_i,
    output logic [31:0] axi_wdata_o,
    output logic [3:0]  axi_wstrb_o,
    output logic        axi_wlast_o,
    input  logic        axi_bvalid_i,
    output logic        axi_bready_o,
    input  logic [1:0]  axi_bresp_i,
    input  logic [4:0]  axi_bid_i,
    output logic        axi_arvalid_o,
    input  logic        axi_arready_i,
    output logic [31:0] axi_araddr_o,
    output logic [4:0]  axi_arid_o,
    output logic [7:0]  axi_arlen_o,
    output logic [1:0]  axi_arburst_o,
    input  logic        axi_rvalid_i,
    output logic        axi_rready_o,
    input  logic [31:0] axi_rdata_i,
    input  logic [1:0]  axi_rresp_i,
    input  logic [4:0]  axi_rid_i,
    input  logic        axi_rlast_i
);
    typedef enum logic [2:0] {IDLE, CALC, AR, R, AW, W, B, DONE} state_t;
    state_t      state_q;
    logic [31:0] addr_q, addr_d;
    logic [15:0] rem_q, rem_d;
    logic [12:0] beats_q, beats_d, rem_clip, to_4k;
    logic [7:0]  len_q, cnt_q;
    logic        write_q, err_q, awvalid_q, arvalid_q, last_beat;
    logic        unused_ok;
    // capping the 16-bit remainder first keeps the 13-bit minimum exact
    assign rem_clip  = (rem_q > 16'(MAX_BURST)) ? 13'(MAX_BURST) : rem_q[12:0];
    assign to_4k     = (13'd4096 - {1'b0, addr_q[11:0]}) >> 2;
    assign beats_d   = (rem_clip < to_4k) ? rem_clip : to_4k;
    assign addr_d    = addr_q + {17'd0, beats_q, 2'b00};
    assign rem_d     = rem_q - {3'd0, beats_q};
    assign last_beat = cnt_q == len_q;
    assign unused_ok = ^{axi_rid_i, cmd_addr_i[1:0]};
    assign cmd_ready_o   = state_q == IDLE;
    assign busy_o        = state_q != IDLE;
    assign done_o        = state_q == DONE;
    assign err_o         = err_q;
    assign axi_awvalid_o = awvalid_q;
    assign axi_awaddr_o  = addr_q;
    assign axi_awid_o    = AXI_ID;
    assign axi_awlen_o   = len_q;
    assign axi_awburst_o = 2'b01;
    assign axi_arvalid_o = arvalid_q;
    assign axi_araddr_o  = addr_q;
    assign axi_arid_o    = AXI_ID;
    assign axi_arlen_o   = len_q;
    assign axi_arburst_o = 2'b01;
    // stream <-> AXI data channels are pass-throughs gated by the data-phase state
    assign axi_wvalid_o  = (state_q == W) && wr_valid_i;
    assign wr_ready_o    = (state_q == W) && axi_wready_i;
    assign axi_wdata_o   = wr_data_i;
    assign axi_wstrb_o   = wr_strb_i;
    assign axi_wlast_o   = (state_q == W) && last_beat;
    assign axi_bready_o  = state_q == B;
    assign axi_rready_o  = (state_q == R) && rd_ready_i;
    assign rd_valid_o    = (state_q == R) && axi_rvalid_i;
    assign rd_data_o     = axi_rdata_i;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            addr_q    <= 32'd0;
            rem_q     <= 16'd0;
            beats_q   <= 13'd0;
            len_q     <= 8'd0;
            cnt_q     <= 8'd0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            awvalid_q <= 1'b0;
            arvalid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (cmd_valid_i) begin
                    addr_q  <= {cmd_addr_i[31:2], 2'b00};
                    rem_q   <= cmd_words_i;
                    write_q <= cmd_write_i;
                    err_q   <= 1'b0;
                    state_q <= (cmd_words_i == 16'd0) ? DONE : CALC;
                end
                CALC: begin
                    beats_q   <= beats_d;
                    len_q     <= 8'(beats_d - 13'd1);
                    awvalid_q <= write_q;
                    arvalid_q <= !write_q;
                    state_q   <= write_q ? AW : AR;
                end
                AR: if (axi_arready_i) begin
                    arvalid_q <= 1'b0;
                    cnt_q     <= 8'd0;
                    state_q   <= R;
                end
                AW: if (axi_awready_i) begin
                    awvalid_q <= 1'b0;
                    cnt_q     <= 8'd0;
                    state_q   <= W;
                end
                R: if (axi_rvalid_i && rd_ready_i) begin
                    // a misplaced or missing rlast is flagged, but the burst still ends on beat len
                    if (axi_rresp_i != 2'b00 || axi_rlast_i != last_beat) err_q <= 1'b1;
                    cnt_q <= cnt_q + 8'd1;
                    if (last_beat) begin
                        addr_q  <= addr_d;
                        rem_q   <= rem_d;
                        state_q <= (rem_d == 16'd0) ? DONE : CALC;
                    end
                end
                W: if (wr_valid_i && axi_wready_i) begin
                    cnt_q <= cnt_q + 8'd1;
                    if (last_beat) state_q <= B;
                end
                B: if (axi_bvalid_i) begin
                    if (axi_bresp_i != 2'b00 || axi_bid_i != AXI_ID) err_q <= 1'b1;
                    addr_q  <= addr_d;
                    rem_q   <= rem_d;
                    state_q <= (rem_d == 16'd0) ? DONE : CALC;
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_burst_master.sv
// tb_axi4_burst_master: directed plus randomized commands against a memory-backed AXI responder and a burst/data model
module tb_axi4_burst_master;
    localparam int MAXB = 16;
    localparam int MW   = 16384;
    logic        clk = 1'b0, rst;
    logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
    logic [31:0] cmd_addr_i;
    logic [15:0] cmd_words_i;
    logic        wr_valid_i, wr_ready_o;
    logic [31:0] wr_data_i;
    logic [3:0]  wr_strb_i;
    logic        rd_valid_o, rd_ready_i;
    logic [31:0] rd_data_o;
    logic        busy_o, done_o, err_o;
    logic        axi_awvalid_o, axi_awready_i;
    logic [31:0] axi_awaddr_o;
    logic [4:0]  axi_awid_o;
    logic [7:0]  axi_awlen_o;
    logic [1:0]  axi_awburst_o;
    logic        axi_wvalid_o, axi_wready_i, axi_wlast_o;
    logic [31:0] axi_wdata_o;
    logic [3:0]  axi_wstrb_o;
    logic        axi_bvalid_i, axi_bready_o;
    logic [1:0]  axi_bresp_i;
    logic [4:0]  axi_bid_i;
    logic        axi_arvalid_o, axi_arready_i;
    logic [31:0] axi_araddr_o;
    logic [4:0]  axi_arid_o;
    logic [7:0]  axi_arlen_o;
    logic [1:0]  axi_arburst_o;
    logic        axi_rvalid_i, axi_rready_o, axi_rlast_i;
    logic [31:0] axi_rdata_i;
    logic [1:0]  axi_rresp_i;
    logic [4:0]  axi_rid_i;

    axi4_burst_master #(.MAX_BURST(MAXB), .AXI_ID(5'd0)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_words_i(cmd_words_i),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i), .wr_strb_i(wr_strb_i),
        .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .axi_awvalid_o(axi_awvalid_o), .axi_awready_i(axi_awready_i), .axi_awaddr_o(axi_awaddr_o),
        .axi_awid_o(axi_awid_o), .axi_awlen_o(axi_awlen_o), .axi_awburst_o(axi_awburst_o),
        .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(axi_wready_i), .axi_wdata_o(axi_wdata_o),
        .axi_wstrb_o(axi_wstrb_o), .axi_wlast_o(axi_wlast_o),
        .axi_bvalid_i(axi_bvalid_i), .axi_bready_o(axi_bready_o), .axi_bresp_i(axi_bresp_i), .axi_bid_i(axi_bid_i),
        .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready_i), .axi_araddr_o(axi_araddr_o),
        .axi_arid_o(axi_arid_o), .axi_arlen_o(axi_arlen_o), .axi_arburst_o(axi_arburst_o),
        .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o), .axi_rdata_i(axi_rdata_i),
        .axi_rresp_i(axi_rresp_i), .axi_rid_i(axi_rid_i), .axi_rlast_i(axi_rlast_i)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_err = 0;
    logic [31:0] mem [MW];
    logic [31:0] exp_mem [MW];
    int          cyc = 0;
    bit          rnd = 1'b0, tog = 1'b0;
    int          rd_mode = 0, fault = 0;
    logic [39:0] obs_b[$];
    logic [31:0] rd_got[$];
    logic [35:0] wr_src[$];
    bit          r_act = 1'b0, w_act = 1'b0, b_pend = 1'b0;
    logic [31:0] r_addr = 32'd0, w_addr = 32'd0;
    int          r_beat = 0, w_beat = 0, r_len = 0, w_len = 0;
    int          done_cnt = 0, viol = 0, first_ax = -1;

    // responder: drive just after posedge, observe the coming handshakes at negedge
    initial forever begin
        @(posedge clk); #1;
        if (rst) begin
            r_act = 1'b0; w_act = 1'b0; b_pend = 1'b0;
            wr_src.delete();
        end
        axi_awready_i = rnd ? 1'($urandom) : 1'b1;
        axi_arready_i = rnd ? 1'($urandom) : 1'b1;
        axi_wready_i  = rnd ? 1'($urandom) : 1'b1;
        axi_bvalid_i  = b_pend && (rnd ? 1'($urandom) : 1'b1);
        axi_bresp_i   = (fault == 1) ? 2'b10 : 2'b00;
        axi_bid_i     = (fault == 3) ? 5'd1 : 5'd0;
        axi_rvalid_i  = r_act && (rnd ? 1'($urandom) : 1'b1);
        axi_rdata_i   = r_act ? mem[int'(r_addr[15:2]) + r_beat] : 32'd0;
        axi_rresp_i   = (fault == 1) ? 2'b10 : 2'b00;
        axi_rlast_i   = r_act && r_beat == r_len && fault != 2;
        tog = !tog;
        rd_ready_i = (rd_mode == 0) ? 1'b1 : (rd_mode == 1) ? tog : 1'($urandom);
        wr_valid_i = wr_src.size() > 0 && (rnd ? 1'($urandom) : 1'b1);
        {wr_strb_i, wr_data_i} = (wr_src.size() > 0) ? wr_src[0] : 36'd0;
        @(negedge clk);
        cyc++;
        if (!rst) begin
            if (done_o) done_cnt++;
            if ((axi_awvalid_o || axi_arvalid_o) && first_ax < 0) first_ax = cyc;
            if ((axi_awvalid_o || axi_arvalid_o) && (r_act || w_act || b_pend)) viol++;
            if (r_act) begin
                if (axi_rready_o !== rd_ready_i || rd_valid_o !== axi_rvalid_i || rd_data_o !== axi_rdata_i) viol++;
            end else if (axi_rready_o !== 1'b0 || rd_valid_o !== 1'b0) viol++;
            if (w_act) begin
                if (axi_wvalid_o !== wr_valid_i || wr_ready_o !== axi_wready_i) viol++;
            end else if (axi_wvalid_o !== 1'b0 || wr_ready_o !== 1'b0) viol++;
            if (axi_bready_o !== b_pend) viol++;
            if (axi_rvalid_i && axi_rready_o) begin
                if (rd_valid_o && rd_ready_i) rd_got.push_back(rd_data_o);
                r_beat++;
                if (r_beat > r_len) r_act = 1'b0;
            end
            if (axi_wvalid_o && axi_wready_i) begin
                if (axi_wlast_o !== (w_beat == w_len)) viol++;
                for (int j = 0; j < 4; j++)
                    if (axi_wstrb_o[j]) mem[int'(w_addr[15:2]) + w_beat][8*j +: 8] = axi_wdata_o[8*j +: 8];
                if (wr_valid_i && wr_ready_o) void'(wr_src.pop_front());
                w_beat++;
                if (w_beat > w_len) begin w_act = 1'b0; b_pend = 1'b1; end
            end
            if (axi_bvalid_i && axi_bready_o) b_pend = 1'b0;
            if (axi_arvalid_o && axi_arready_i) begin
                obs_b.push_back({axi_arlen_o, axi_araddr_o});
                if (axi_arburst_o !== 2'b01 || axi_arid_o !== 5'd0) viol++;
                r_act = 1'b1; r_addr = axi_araddr_o; r_len = int'(axi_arlen_o); r_beat = 0;
            end
            if (axi_awvalid_o && axi_awready_i) begin
                obs_b.push_back({axi_awlen_o, axi_awaddr_o});
                if (axi_awburst_o !== 2'b01 || axi_awid_o !== 5'd0) viol++;
                w_act = 1'b1; w_addr = axi_awaddr_o; w_len = int'(axi_awlen_o); w_beat = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // model: bursts are min(remaining, MAXB, words left in the 4 KB page); data follows a flat word memory
    task automatic run(input bit w, input logic [31:0] a, input int n, input int flt, input int exp_lat, input string tag);
        logic [31:0] ea, d;
        logic [3:0]  s;
        int          rem, b, idx, acc, k, bad;
        logic [39:0] exp_b[$];
        logic [31:0] exp_rd[$];
        ea = {a[31:2], 2'b00};
        rem = n;
        while (rem > 0) begin
            b = (rem < MAXB) ? rem : MAXB;
            if (b > (4096 - int'(ea[11:0])) / 4) b = (4096 - int'(ea[11:0])) / 4;
            exp_b.push_back({8'(b - 1), ea});
            ea = ea + 32'(4 * b);
            rem = rem - b;
        end
        for (int i = 0; i < n; i++) begin
            idx = int'(a[15:2]) + i;
            if (w) begin
                d = $urandom; s = 4'($urandom);
                wr_src.push_back({s, d});
                for (int j = 0; j < 4; j++) if (s[j]) exp_mem[idx][8*j +: 8] = d[8*j +: 8];
            end else exp_rd.push_back(exp_mem[idx]);
        end
        fault = flt; obs_b.delete(); rd_got.delete(); done_cnt = 0; viol = 0; first_ax = -1;
        @(posedge clk); #2;
        cmd_valid_i = 1'b1; cmd_write_i = w; cmd_addr_i = a; cmd_words_i = 16'(n);
        k = 0;
        do begin @(negedge clk); #1; k++; end while (!cmd_ready_o && k < 100);
        acc = cyc;
        @(posedge clk); #2;
        cmd_valid_i = 1'b0;
        @(negedge clk); #1;
        check({tag, " err clr"}, err_o, 0);
        k = 0;
        while (!done_o && k < 3000) begin @(negedge clk); #1; k++; end
        check({tag, " done"}, done_o, 1);
        if (exp_lat >= 0) check({tag, " latency"}, cyc - acc, exp_lat);
        if (n > 0) check({tag, " ax start"}, first_ax - acc, 2);
        check({tag, " busy/ready at done"}, {busy_o, cmd_ready_o}, 2'b10);
        check({tag, " err"}, err_o, (flt != 0 && n > 0));
        @(negedge clk); #1;
        check({tag, " ready again"}, {done_o, busy_o, cmd_ready_o}, 3'b001);
        check({tag, " done count"}, done_cnt, 1);
        check({tag, " burst count"}, obs_b.size(), exp_b.size());
        foreach (exp_b[i]) if (i < obs_b.size()) check($sformatf("%s burst%0d", tag, i), obs_b[i], exp_b[i]);
        if (!w) begin
            check({tag, " rd count"}, rd_got.size(), exp_rd.size());
            foreach (exp_rd[i]) if (i < rd_got.size()) check($sformatf("%s rd%0d", tag, i), rd_got[i], exp_rd[i]);
        end else begin
            bad = 0;
            for (int i = 0; i < n; i++) if (mem[int'(a[15:2]) + i] !== exp_mem[int'(a[15:2]) + i]) bad++;
            check({tag, " mem"}, bad, 0);
            check({tag, " wr consumed"}, wr_src.size(), 0);
        end
        check({tag, " protocol"}, viol, 0);
    endtask

    initial begin
        bit          w;
        int          n, flt, k;
        logic [31:0] a;
        rst = 1'b1;
        cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = 32'd0; cmd_words_i = 16'd0;
        wr_valid_i = 1'b0; wr_data_i = 32'd0; wr_strb_i = 4'd0; rd_ready_i = 1'b0;
        axi_awready_i = 1'b0; axi_wready_i = 1'b0; axi_bvalid_i = 1'b0; axi_bresp_i = 2'd0; axi_bid_i = 5'd0;
        axi_arready_i = 1'b0; axi_rvalid_i = 1'b0; axi_rdata_i = 32'd0; axi_rresp_i = 2'd0;
        axi_rid_i = 5'd0; axi_rlast_i = 1'b0;
        for (int i = 0; i < MW; i++) begin mem[i] = $urandom; exp_mem[i] = mem[i]; end
        #3;
        check("reset valids", {axi_awvalid_o, axi_arvalid_o, axi_wvalid_o, axi_bready_o, axi_rready_o}, 0);
        check("reset streams", {rd_valid_o, wr_ready_o, done_o, err_o, busy_o}, 0);
        check("reset cmd_ready", cmd_ready_o, 1);
        check("reset burst", {axi_awburst_o, axi_arburst_o}, 4'b0101);
        check("reset addr/len", {axi_awaddr_o, axi_awlen_o, axi_araddr_o, axi_arlen_o}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run(1'b1, 32'h100, 4, 0, 8, "single write");
        run(1'b0, 32'h0, 20, 0, -1, "split read");
        run(1'b0, 32'hFF8, 4, 0, -1, "4k read");
        rd_mode = 1;
        run(1'b0, 32'h200, 8, 0, -1, "backpressure");
        rd_mode = 0;
        run(1'b1, 32'h300, 2, 1, -1, "bresp err");
        run(1'b0, 32'h300, 0, 0, 1, "zero words");
        for (int i = 0; i < 8; i++) wr_src.push_back({4'hF, 32'(i)});
        @(posedge clk); #2;
        cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 32'hC000; cmd_words_i = 16'd8;
        @(posedge clk); #2;
        cmd_valid_i = 1'b0;
        k = 0;
        while (!(w_act && w_beat == 2) && k < 50) begin @(negedge clk); #1; k++; end
        check("rst at beat2", w_beat, 2);
        rst = 1'b1; #1;
        check("rst async drop", {axi_awvalid_o, axi_arvalid_o, axi_wvalid_o, axi_bready_o, axi_rready_o,
                                 wr_ready_o, rd_valid_o, busy_o, done_o}, 0);
        check("rst cmd_ready", cmd_ready_o, 1);
        @(negedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        check("post rst idle", {cmd_ready_o, busy_o, w_act}, 3'b100);
        run(1'b0, 32'h400, 1, 0, -1, "post rst read");
        rnd = 1'b1; rd_mode = 2;
        for (int t = 0; t < 30; t++) begin
            w = 1'($urandom);
            n = int'($urandom_range(0, 40));
            if ($urandom_range(0, 2) == 0) a = 32'($urandom_range(1, 7)) * 32'h1000 - 32'(4 * $urandom_range(1, 20));
            else a = 32'($urandom_range(0, 8000)) << 2;
            a = a | 32'($urandom_range(0, 3));
            flt = (t % 4 == 3) ? (w ? ($urandom_range(0, 1) == 0 ? 1 : 3) : ($urandom_range(0, 1) == 0 ? 1 : 2)) : 0;
            run(w, a, n, flt, -1, $sformatf("rnd%0d", t));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
